// File: rtl/uart_pkg.sv
// Shared definitions for the multi-byte UART transmitter.
// Contents:
//   tx_state_t           - transmit state machine encoding
//   DEFAULT_CLKS_PER_BIT - 50 MHz clock / 230400 baud
//   clog2_min1()         - $clog2 clamped to a minimum of 1, for field widths
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    // A field holding a count of 1 still needs one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous single-clock FIFO holding whole transmit words ({len, data}).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   wr_en, wr_data    - push; ignored while full
//   rd_en, rd_data    - pop; rd_data shows the head entry while !empty
//   full, empty       - occupancy flags, derived from the registered count
//   level             - number of entries held (0..DEPTH)
module uart_word_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    // full/empty come from the count before this cycle's pop, so a write
    // arriving while full is dropped even if a pop happens in the same cycle.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter. Words of 1..MAX_BYTES bytes are queued in a
// FIFO and sent as back-to-back 8N1/8N2 frames, byte0 (wr_data[7:0]) first,
// LSB first. halt and cts_n are only looked at between words.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   wr_en, wr_data       - push one word
//   wr_len               - bytes minus 1, clamped to MAX_BYTES-1
//   halt                 - level; blocks the start of a new word
//   cts_n                - host clear-to-send, active-low, asynchronous
//   tx                   - serial line, idle high
//   busy                 - from word pop until the last stop bit ends
//   word_done            - one-cycle pulse at the end of each word
//   full, empty, level   - FIFO status
//   overflow             - sticky, set by a write while full
//
// Write handshake: a word is taken on any clock edge where wr_en is high and
// full is low. There is no back-pressure wait; a wr_en while full is lost
// and latches overflow until reset.
//
// The FSM state is held in the signal 'state' (type tx_state_t).
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_BYTES    = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int LEN_W        = clog2_min1(MAX_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [8*MAX_BYTES-1:0]        wr_data,
    input  logic [LEN_W-1:0]              wr_len,
    input  logic                          halt,
    input  logic                          cts_n,
    output logic                          tx,
    output logic                          busy,
    output logic                          word_done,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int DW       = 8 * MAX_BYTES;
    localparam int FW       = LEN_W + DW;
    localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
    localparam int TW       = clog2_min1(STOP_CYC);

    localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_BYTES - 1);
    localparam logic [TW-1:0]    BIT_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]    STOP_LOAD  = TW'(STOP_CYC - 1);

    // ---------------------------------------------------------------- FIFO
    logic [LEN_W-1:0] len_clamped;
    logic [FW-1:0]    fifo_rd;
    logic             pop;

    assign len_clamped = (wr_len > LEN_MAX) ? LEN_MAX : wr_len;

    uart_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({len_clamped, wr_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------- CTS synchroniser
    // Resets to "not clear" so nothing starts until the host is seen ready.
    logic [1:0] cts_ff;
    logic       cts_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_ff <= 2'b11;
        end else begin
            cts_ff <= {cts_ff[0], cts_n};
        end
    end

    assign cts_sync = cts_ff[1];

    // --------------------------------------------------------------- FSM
    tx_state_t        state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [DW-1:0]    shreg, shreg_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [LEN_W-1:0] bytes_left, bytes_left_n;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            bytes_left <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            shreg      <= shreg_n;
            bit_idx    <= bit_idx_n;
            bytes_left <= bytes_left_n;
            tx_q       <= tx_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    // The timer is reloaded at every bit boundary, so each bit is exactly
    // CLKS_PER_BIT cycles. tx is registered and changes on the same edge as
    // the state, which keeps the line glitch-free.
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        shreg_n      = shreg;
        bit_idx_n    = bit_idx;
        bytes_left_n = bytes_left;
        tx_n         = tx_q;
        busy_n       = busy_q;
        done_n       = 1'b0;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty && !halt && !cts_sync) begin
                    pop          = 1'b1;
                    state_n      = START;
                    tx_n         = 1'b0;
                    busy_n       = 1'b1;
                    timer_n      = BIT_RELOAD;
                    shreg_n      = fifo_rd[DW-1:0];
                    bytes_left_n = fifo_rd[FW-1:DW];
                end
            end

            START: begin
                if (timer == '0) begin
                    state_n   = DATA;
                    tx_n      = shreg[0];
                    timer_n   = BIT_RELOAD;
                    bit_idx_n = 3'd0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end

            DATA: begin
                if (timer == '0) begin
                    // The whole word shifts; after 8 shifts the next byte
                    // sits in shreg[7:0] ready for its own frame.
                    shreg_n = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                        timer_n = STOP_LOAD;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[1];
                        timer_n   = BIT_RELOAD;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end

            STOP: begin
                if (timer == '0) begin
                    if (bytes_left != '0) begin
                        // Next byte of the same word: no gap, no CTS/halt check.
                        state_n      = START;
                        tx_n         = 1'b0;
                        timer_n      = BIT_RELOAD;
                        bytes_left_n = bytes_left - LEN_W'(1);
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT 1: STOP_BITS=1
    logic        wr_en;
    logic [31:0] wr_data;
    logic [1:0]  wr_len;
    logic        halt;
    logic        cts_n;
    logic        tx, busy, word_done, full, empty, overflow;
    logic [3:0]  level;

    // DUT 2: STOP_BITS=2
    logic        wr_en2;
    logic [31:0] wr_data2;
    logic [1:0]  wr_len2;
    logic        halt2;
    logic        cts_n2;
    logic        tx2, busy2, word_done2, full2, empty2, overflow2;
    logic [3:0]  level2;

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .MAX_BYTES    (4),
        .FIFO_DEPTH   (8),
        .STOP_BITS    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_len    (wr_len),
        .halt      (halt),
        .cts_n     (cts_n),
        .tx        (tx),
        .busy      (busy),
        .word_done (word_done),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .MAX_BYTES    (4),
        .FIFO_DEPTH   (8),
        .STOP_BITS    (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en2),
        .wr_data   (wr_data2),
        .wr_len    (wr_len2),
        .halt      (halt2),
        .cts_n     (cts_n2),
        .tx        (tx2),
        .busy      (busy2),
        .word_done (word_done2),
        .full      (full2),
        .empty     (empty2),
        .level     (level2),
        .overflow  (overflow2)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_done = 0;

    logic [7:0] exp_q[$];
    int         exp_dur_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [31:0] d, input logic [1:0] len, input bit accept);
        wr_data = d;
        wr_len  = len;
        wr_en   = 1'b1;
        step(1);
        wr_en   = 1'b0;
        if (accept) begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_q.push_back(d[8*i +: 8]);
            end
            exp_dur_q.push_back((int'(len) + 1) * 10 * CPB);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i;
        i = 0;
        while (i < budget && !(exp_q.size() == 0 && exp_dur_q.size() == 0 && !busy && empty)) begin
            step(1);
            i++;
        end
        check({"drain_", tag}, exp_q.size() + exp_dur_q.size(), 0);
    endtask

    // Frame monitor: on a falling tx, samples every cycle of start, 8 data
    // and 1 stop bit; each bit must hold its value for CPB cycles.
    initial begin : tx_mon
        logic [7:0] byte_v;
        logic       val;
        bit         ok;
        bit         abort;
        val = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ok     = 1'b1;
                abort  = 1'b0;
                byte_v = 8'h00;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int c = 0; c < CPB && !abort; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) abort = 1'b1;
                        else if (c == 0) val = tx;
                        else if (tx !== val) ok = 1'b0;
                    end
                    if (!abort) begin
                        if (b >= 1 && b <= 8) byte_v[b-1] = val;
                        else if (b == 0 && val !== 1'b0) ok = 1'b0;
                        else if (b == 9 && val !== 1'b1) ok = 1'b0;
                    end
                end
                if (!abort) begin
                    check("frame_shape", ok, 1);
                    if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
                    else check("rx_byte", byte_v, exp_q.pop_front());
                end
            end
        end
    end

    // Word monitor: busy rise to word_done must match the word length.
    initial begin : done_mon
        int   cyc;
        int   start_cyc;
        logic prev_busy;
        logic prev_done;
        cyc = 0;
        start_cyc = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (busy && !prev_busy) start_cyc = cyc;
                if (word_done) begin
                    n_done++;
                    check("done_single", prev_done, 0);
                    check("busy_at_done", busy, 0);
                    if (exp_dur_q.size() == 0) check("unexpected_done", n_done, 0);
                    else check("word_time", cyc - start_cyc, exp_dur_q.pop_front());
                end
                prev_busy = busy;
                prev_done = word_done;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic [7:0]  b2;
        bit          stop_ok;
        bit          early;
        int          done0;
        int          i;

        wr_en = 0; wr_data = 0; wr_len = 0; halt = 0; cts_n = 0;
        wr_en2 = 0; wr_data2 = 0; wr_len2 = 0; halt2 = 0; cts_n2 = 0;

        // Reset state
        rst = 1'b1;
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", word_done, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        step(3);

        // Single byte 0xA5, latency from write to tx fall
        write_word(32'h0000_00A5, 2'd0, 1'b1);
        check("lat_empty", empty, 0);
        check("lat_level", level, 1);
        check("lat_tx_high", tx, 1);
        step(1);
        check("lat_tx_fall", tx, 0);
        check("lat_busy", busy, 1);
        check("lat_level_pop", level, 0);
        wait_idle(200, "a5");

        // Three bytes back-to-back
        write_word(32'h0003_0201, 2'd2, 1'b1);
        wait_idle(400, "three");

        // Fill with CTS blocked, then overflow
        cts_n = 1'b1;
        step(3);
        for (int k = 0; k < 8; k++) begin
            rd = $urandom;
            write_word(rd, 2'($urandom_range(0, 3)), 1'b1);
        end
        check("fill_full", full, 1);
        check("fill_level", level, 8);
        check("fill_no_ovf", overflow, 0);
        check("cts_blk_busy", busy, 0);
        check("cts_blk_tx", tx, 1);
        write_word(32'hDEAD_BEEF, 2'd3, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_full", full, 1);
        check("ovf_level", level, 8);
        cts_n = 1'b0;
        step(2);
        check("cts_sync_hold", tx, 1);
        step(1);
        check("cts_release_fall", tx, 0);
        wait_idle(5000, "fill");
        check("drain_level", level, 0);
        check("drain_empty", empty, 1);
        check("ovf_sticky", overflow, 1);

        // Halt blocks the start of a word
        halt = 1'b1;
        write_word(32'h0000_0081, 2'd0, 1'b1);
        step(10);
        check("halt_busy", busy, 0);
        check("halt_tx", tx, 1);
        check("halt_level", level, 1);
        halt = 1'b0;
        wait_idle(300, "halt");

        // CTS raised during byte 1 of a 2-byte word
        write_word(32'h0000_C3B4, 2'd1, 1'b1);
        write_word(32'h0000_7E18, 2'd1, 1'b1);
        step(50);
        cts_n = 1'b1;
        done0 = n_done;
        i = 0;
        while (i < 200 && n_done == done0) begin
            step(1);
            i++;
        end
        check("cts_word_done", n_done, done0 + 1);
        step(20);
        check("cts_stop_busy", busy, 0);
        check("cts_stop_tx", tx, 1);
        check("cts_stop_level", level, 1);
        cts_n = 1'b0;
        wait_idle(400, "cts");

        // Asynchronous reset in the middle of data bit 3
        write_word(32'h0000_00F0, 2'd0, 1'b1);
        write_word(32'h0000_0011, 2'd0, 1'b1);
        step(17);
        check("pre_rst_tx", tx, 0);
        check("pre_rst_level", level, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        check("arst_overflow", overflow, 0);
        exp_q.delete();
        exp_dur_q.delete();
        step(2);
        rst = 1'b0;
        step(2);
        write_word(32'h0000_003C, 2'd0, 1'b1);
        wait_idle(200, "post_rst");

        // STOP_BITS=2: 8-cycle stop, 44-cycle word
        wr_data2 = 32'h0000_0096;
        wr_len2  = 2'd0;
        wr_en2   = 1'b1;
        step(1);
        wr_en2   = 1'b0;
        step(1);
        check("sb2_fall", tx2, 0);
        b2      = 8'h00;
        stop_ok = 1'b1;
        early   = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c >= 4 && c < 36 && (c % 4) == 2) b2[(c-4)/4] = tx2;
            if (c >= 36 && tx2 !== 1'b1) stop_ok = 1'b0;
            if (word_done2) early = 1'b1;
            step(1);
        end
        check("sb2_byte", b2, 8'h96);
        check("sb2_stop_high", stop_ok, 1);
        check("sb2_no_early_done", early, 0);
        check("sb2_done_at_44", word_done2, 1);
        check("sb2_busy_end", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised multi-byte UART transmitter. It is the successor to the fixed one/two-byte PMT count sender. It accepts words of 1..MAX_BYTES bytes (e.g. PMT1, PMT2, sum, timebin) into a small FIFO and serialises each word as back-to-back 8N1/8N2 frames. Flow control and halt act only at word boundaries. It sits between the timebin counter logic and the host serial line.

Parameters:
CLKS_PER_BIT, 217, clk cycles per serial bit (50 MHz / 230400 baud); legal range 2..65535.
MAX_BYTES, 4, maximum bytes per word; legal range 1..8.
FIFO_DEPTH, 8, number of word entries; power of 2, at least 2.
STOP_BITS, 1, stop bits per byte; 1 or 2.
LEN_W, $clog2(MAX_BYTES) (minimum 1), derived width of the length field.

Ports:
clk  in  1  master clock
rst  in  1  reset; asynchronous, active-high
wr_en  in  1  push one word into the FIFO
wr_data  in  8*MAX_BYTES  word to send; byte0 = [7:0] is sent first
wr_len  in  LEN_W  number of bytes minus 1; values above MAX_BYTES-1 are clamped to MAX_BYTES-1
halt  in  1  level; when high, no new word is started
cts_n  in  1  host clear-to-send, active-low, asynchronous; a 2-flop synchroniser is internal
tx  out  1  serial line, idle high
busy  out  1  high from word pop until the final stop bit ends
word_done  out  1  one-cycle pulse at the end of each word's last stop bit
full  out  1  FIFO full
empty  out  1  FIFO empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky; set when wr_en is asserted while full; cleared only by rst

Behaviour:
- Reset, asynchronous: tx=1, busy=0, word_done=0, FIFO emptied (empty=1, full=0, level=0), overflow=0, state IDLE, synchroniser flops=1. A reset mid-frame truncates the frame; tx returns high immediately.
- FIFO entry: {len, data}. Write is accepted when wr_en && !full. A write while full is dropped and sets overflow. A simultaneous write and pop when full: the pop happens and the write is still dropped, because full is evaluated before the pop.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: if !empty && !halt && cts_sync==0, pop the entry, load the shift register and byte counter, set busy=1, tx=0, and go to START. Otherwise stay, with tx=1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=bit0.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first, 8 bits. After bit7, go to STOP with tx=1.
  - STOP: hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - If bytes remain: go to START with tx=0 and the next byte loaded. There is no extra gap and no CTS/halt check inside a word.
    - If no bytes remain: pulse word_done, set busy=0, go to IDLE. If the FIFO is non-empty and still permitted, IDLE starts the next word on the following cycle (1 idle-high cycle between words).
- Bit timer: down-counter reloaded at every bit boundary. Every bit is exactly CLKS_PER_BIT cycles; there is no drift across bits.
- Latency: wr_en sampled at edge k into an empty FIFO while IDLE and permitted gives empty=0 after edge k and tx falling after edge k+1.
- Word duration: (len+1)*(9+STOP_BITS)*CLKS_PER_BIT cycles from the tx fall to the word_done pulse edge.
- Halt or cts_n rising mid-word: the current word completes; no new word starts.
- level arithmetic: +1 on accepted write, -1 on pop, unchanged on both. It never wraps.

Decomposition:
- Package uart_pkg: tx state enum (IDLE/START/DATA/STOP), the default CLKS_PER_BIT constant, and the function clog2_min1.
- Sub-module uart_word_fifo: synchronous FIFO of width LEN_W+8*MAX_BYTES and depth FIFO_DEPTH, with full/empty/level outputs and registered pointers.
- The top module holds the synchroniser, bit timer and FSM.

Test Plan:
- CLKS_PER_BIT=4, write data 0x..A5 with len=0 → tx: start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles; word_done pulses once, 40 cycles after the tx fall.
- len=2, data 0x0302_01 → three frames 0x01, 0x02, 0x03 back-to-back; no idle between the stop bit and the next start bit; one word_done.
- Fill the FIFO with 8 words, then a 9th write → full=1, overflow=1; the 9th word is never transmitted; all 8 words go out in order; level goes 8→0.
- cts_n=1 with 2 words queued → tx stays 1 and busy=0. Release cts_n → first tx fall 3 cycles later. Raise cts_n during byte 1 of a 2-byte word → that word completes, the next does not start.
- Assert rst during DATA bit 3 → tx=1 in the same cycle, no clock needed; level=0; after release, a new write transmits cleanly.
- STOP_BITS=2, len=0 → stop period is 8 cycles; word time is 44 cycles.
